// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: source-select codes,
// scan FSM states and the hex-to-segment pattern table (active-low {g..a}).
package seg_pkg;

   typedef enum logic [2:0] {
      SEL_RAM       = 3'd0,
      SEL_CYCLES    = 3'd1,
      SEL_CONDI     = 3'd2,
      SEL_UNCONDI   = 3'd3,
      SEL_CONDI_SUC = 3'd4,
      SEL_SYSCALL   = 3'd5,
      SEL_PC        = 3'd6,
      SEL_ZERO      = 3'd7
   } disp_sel_e;

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      ON    = 2'd1,
      DEAD  = 2'd2
   } scan_state_e;

   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam logic [6:0] HEX_SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of display sources, source select and the multiplexed digit outputs.
interface seg_scan_ctrl_if;
   logic [2:0]  display;
   logic [31:0] ram_display;
   logic [31:0] total_cycles;
   logic [31:0] condi_num;
   logic [31:0] uncondi_num;
   logic [31:0] condi_suc_num;
   logic [31:0] SyscallOut;
   logic [11:0] pc;
   logic [7:0]  AN;
   logic [7:0]  SEG;

   modport master (
      output display, ram_display, total_cycles, condi_num, uncondi_num,
             condi_suc_num, SyscallOut, pc,
      input  AN, SEG
   );

   modport slave (
      input  display, ram_display, total_cycles, condi_num, uncondi_num,
             condi_suc_num, SyscallOut, pc,
      output AN, SEG
   );
endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern decode.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);
   assign seg = HEX_SEG_TABLE[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with per-slot dead-time blanking.
// Define SEG_LZ_BLANK_EN to suppress leading-zero digits.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int DEAD_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  display,
   input  logic [31:0] ram_display,
   input  logic [31:0] total_cycles,
   input  logic [31:0] condi_num,
   input  logic [31:0] uncondi_num,
   input  logic [31:0] condi_suc_num,
   input  logic [31:0] SyscallOut,
   input  logic [11:0] pc,
   output logic [7:0]  AN,
   output logic [7:0]  SEG
);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   // ON is left one cycle early so that DEAD covers exactly the last DEAD_CYCLES of the slot.
   localparam logic [DIV_W-1:0] DEAD_ENTER = DIV_W'(REFRESH_DIV - DEAD_CYCLES - 1);
   localparam bit HAS_DEAD = (DEAD_CYCLES != 0);

   scan_state_e      state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       dig_q, dig_d;
   logic [31:0]      snap_q, snap_d;
   logic [7:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;

   logic [31:0] src_sel;
   logic        slot_end;
   logic [3:0]  cur_nib;
   logic [6:0]  cur_pat;
   logic [7:0]  lz_blank;

   always_comb begin
      src_sel = 32'h0;
      case (disp_sel_e'(display))
         SEL_RAM:       src_sel = ram_display;
         SEL_CYCLES:    src_sel = total_cycles;
         SEL_CONDI:     src_sel = condi_num;
         SEL_UNCONDI:   src_sel = uncondi_num;
         SEL_CONDI_SUC: src_sel = condi_suc_num;
         SEL_SYSCALL:   src_sel = SyscallOut;
         SEL_PC:        src_sel = {20'h0, pc};
         default:       src_sel = 32'h0;
      endcase
   end

`ifdef SEG_LZ_BLANK_EN
   assign lz_blank[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_lz
         assign lz_blank[gi] = (snap_q[31:4*gi] == '0);
      end
   endgenerate
`else
   assign lz_blank = 8'h00;
`endif

   assign cur_nib = snap_q[{dig_q, 2'b00} +: 4];

   hex_to_seg u_hex (
      .nibble (cur_nib),
      .seg    (cur_pat)
   );

   assign slot_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      dig_d   = dig_q;
      snap_d  = snap_q;
      div_d   = slot_end ? '0 : div_q + 1'b1;
      an_d    = AN_OFF;
      seg_d   = SEG_OFF;

      case (state_q)
         BLANK: begin
            if (slot_end) begin
               state_d = ON;
               snap_d  = src_sel;
            end
         end
         ON: begin
            if (HAS_DEAD && div_q == DEAD_ENTER) state_d = DEAD;
         end
         DEAD: begin
            if (slot_end) state_d = ON;
         end
         default: state_d = BLANK;
      endcase

      // The digit index stays parked at 0 through the initial BLANK slot.
      if (state_q != BLANK && slot_end) begin
         dig_d = dig_q + 3'd1;
         if (dig_q == 3'd7) snap_d = src_sel;
      end

      if (state_q == ON && !lz_blank[dig_q]) begin
         an_d  = ~(8'h01 << dig_q);
         seg_d = {1'b1, cur_pat};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BLANK;
         div_q   <= '0;
         dig_q   <= 3'd0;
         snap_q  <= 32'h0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         dig_q   <= dig_d;
         snap_q  <= snap_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal range >= 2).
REQ-002 SHALL have parameter DEAD_CYCLES, default 1000, blanking cycles at the end of each slot (legal range 0 .. REFRESH_DIV-1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock (board clock, undivided).
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port display, input, 3 bits, source select.
REQ-006 SHALL have ports ram_display, total_cycles, condi_num, uncondi_num, condi_suc_num and SyscallOut, each input, 32 bits, pipeline display sources.
REQ-007 SHALL have port pc, input, 12 bits, current fetch PC.
REQ-008 SHALL have port AN, output, 8 bits, active-low digit enables.
REQ-009 SHALL have port SEG, output, 8 bits, active-low segments: {dp,g,f,e,d,c,b,a}.

Function
REQ-010 SHALL decode display as: 0 ram_display; 1 total_cycles; 2 condi_num; 3 uncondi_num; 4 condi_suc_num; 5 SyscallOut; 6 pc zero-extended to 32 bits; 7 32'h0.
REQ-011 SHALL keep a slot counter div (0..REFRESH_DIV-1) and a digit index dig (0..7); at div==REFRESH_DIV-1, div->0 and dig increments, wrapping 7->0.
REQ-012 SHALL implement FSM {BLANK, ON, DEAD}:
- BLANK->ON after one full slot.
- ON->DEAD at div==REFRESH_DIV-DEAD_CYCLES.
- DEAD->ON at slot end.
- If DEAD_CYCLES==0, DEAD is never entered.
REQ-013 SHALL load a 32-bit snapshot from the selected source on the BLANK->ON transition and on every dig 7->0 wrap; no other cycle updates the snapshot.
REQ-014 SHALL, in ON, drive AN with only bit dig low and SEG[6:0] with the hex pattern of snapshot[4*dig+3:4*dig]; SEG[7] SHALL be 1 (dp off).
REQ-015 SHALL, in BLANK and DEAD, drive AN=8'hFF and SEG=8'hFF.
REQ-016 SHALL register AN and SEG: they reflect the state/div/dig of the previous cycle (1-cycle latency).
REQ-017 SHALL use hex patterns (SEG[6:0]): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-018 SHALL keep a frame intact when display or the sources change mid-frame; the change becomes visible from the next frame's digit 0.
REQ-019 SHALL never drive more than one AN bit low in any cycle.

Reset
REQ-020 SHALL, while rst=1, hold AN=8'hFF, SEG=8'hFF, div=0, dig=0, state=BLANK and snapshot=0, independent of clk.
REQ-021 SHALL treat rst asserted mid-frame as a full reset; scanning restarts with a BLANK slot.

Configuration
REQ-022 SHALL, when SEG_LZ_BLANK_EN is defined, blank leading-zero digits: digit k is blanked (AN bit stays 1, SEG=8'hFF during its ON window) when all nibbles k..7 of the snapshot are zero and k != 0.
REQ-023 SHALL, when SEG_LZ_BLANK_EN is not defined, display all 8 digits including leading zeros.

Structure
REQ-024 SHALL take the display-select encodings, FSM state enum and the 16-entry hex pattern table from shared package seg_pkg.
REQ-025 SHALL place nibble-to-pattern decode in combinational sub-module hex_to_seg (4-bit in, 7-bit out).

Verification
REQ-026 Parameters for all scenarios are REFRESH_DIV=4, DEAD_CYCLES=1.
REQ-027 The bench SHALL cover each scenario below:
- Reset release, display=1, total_cycles=32'h0000_0000: AN=FF and SEG=FF for 4 cycles (+1 latency), then AN=FE with SEG=C0 for 3 cycles, then AN=FF for 1 cycle, then AN=FD.
- display=6, pc=12'h0A4, macro off: frame shows digits 0..7 = 4,A,0,0,0,0,0,0, i.e. SEG=99, 88, then C0 six times.
- Same stimulus with SEG_LZ_BLANK_EN defined: digits 0..1 show 99, 88; AN stays FF in digit 2..7 slots.
- display switched 1->5 during digit 3 of a frame: digits 4..7 still come from the total_cycles snapshot; the SyscallOut value appears from the next digit 0.
- rst pulsed for 1 cycle during digit 5 ON: AN=FF asynchronously, then a full BLANK slot, then digit 0.
- Over the whole run, an assertion checks that AN has at most one zero bit and that SEG==FF whenever AN==FF.
